overture_cond_branch_ctrl: RTL

- Sequencer for the OVERTURE condition datapath and program counter.
- Accepts one decoded instruction byte per handshake and advances PC by 1 for non-condition instructions.
- For condition-class instructions, samples the condition operand (REG3) one cycle later and evaluates the 3-bit condition code.
- Loads PC from the jump target (REG0) when the condition is taken; otherwise advances PC by 1. Sits between instruction fetch/decode and program memory addressing.

---
 rtl/overture_cond_branch_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/overture_cond_branch_ctrl.sv
// OVERTURE conditional branch sequencer: steps the PC, resolves conditional jumps.
// Optional taken-jump counter is built when OVERTURE_COND_STATS_EN is defined.
module overture_cond_branch_ctrl #(
  parameter int unsigned PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          instr_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic                halt_i,
  input  logic [7:0]          cond_value_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                taken_o,
`ifdef OVERTURE_COND_STATS_EN
  input  logic                stats_clr_i,
  output logic [15:0]         taken_count_o,
`endif
  output logic                busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cc_q, cc_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                taken_q, taken_d;
  logic                accept;
  logic                is_cond;
  logic                v_neg, v_zero, v_pos;
  logic                taken_c;
  logic                resolve_taken;

  assign instr_ready_o = (state_q == IDLE) && !halt_i;
  assign accept        = instr_valid_i && instr_ready_o;
  assign is_cond       = (instr_i[7:6] == 2'b11);

  assign v_neg  = cond_value_i[7];
  assign v_zero = (cond_value_i == 8'h00);
  assign v_pos  = !v_neg && !v_zero;

  // Evaluate the latched condition code against the current operand
  always_comb begin
    taken_c = 1'b0;
    unique case (cc_q)
      3'd0: taken_c = 1'b0;
      3'd1: taken_c = v_zero;
      3'd2: taken_c = v_neg;
      3'd3: taken_c = v_neg || v_zero;
      3'd4: taken_c = 1'b1;
      3'd5: taken_c = !v_zero;
      3'd6: taken_c = !v_neg;
      3'd7: taken_c = v_pos;
      default: taken_c = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; halt freezes the FSM
  always_comb begin
    state_d = state_q;
    if (!halt_i) begin
      unique case (state_q)
        IDLE: if (accept && is_cond) state_d = EVAL;
        EVAL: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: pc step/jump, taken pulse, latched condition code
  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    cc_d    = cc_q;
    if (!halt_i) begin
      taken_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_cond) cc_d = instr_i[2:0];
            else         pc_d = pc_q + 1'b1;
          end
        end
        EVAL: begin
          if (taken_c) begin
            pc_d    = jump_target_i;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      cc_q    <= 3'd0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      cc_q    <= cc_d;
    end
  end

  assign resolve_taken = !halt_i && (state_q == EVAL) && taken_c;
  assign pc_o          = pc_q;
  assign taken_o       = taken_q;
  assign busy_o        = (state_q == EVAL);

`ifdef OVERTURE_COND_STATS_EN
  logic [15:0] taken_count_q;

  // Saturating taken-jump counter; a clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_count_q <= 16'h0000;
    end else if (!halt_i) begin
      if (stats_clr_i) begin
        taken_count_q <= 16'h0000;
      end else if (resolve_taken && taken_count_q != 16'hFFFF) begin
        taken_count_q <= taken_count_q + 16'h0001;
      end
    end
  end

  assign taken_count_o = taken_count_q;
`else
  logic unused_resolve;
  assign unused_resolve = resolve_taken;
`endif

endmodule
